// File: rtl/chan_pkg.sv
// Shared definitions for the Gilbert-Elliott channel model: the PRNG
// polynomial, the channel state encoding and the default error thresholds.
package chan_pkg;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] LFSR16_POLY  = 16'hB400;
  localparam logic [15:0] LFSR16_SEED  = 16'hACE1;

  // Default thresholds: roughly 0.1 % error rate when good, 25 % when bad
  localparam logic [16:0] THR_GOOD_DEF = 17'd66;
  localparam logic [16:0] THR_BAD_DEF  = 17'd16384;

  // Channel condition as produced by the Gilbert FSM
  typedef enum logic {
    CH_BAD  = 1'b0,
    CH_GOOD = 1'b1
  } channel_state_e;

endpackage

// File: rtl/gilbert_error_injector_if.sv
// Stream bundle for the error injector: the upstream word channel (s_*) and
// the downstream corrupted-word channel (m_*). The master side is whoever
// feeds words in and drains them; the slave side is the injector itself.
interface gilbert_error_injector_if #(
  parameter int DATA_W = 8
);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [DATA_W-1:0] m_err_mask;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_err_mask
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_err_mask
  );

endinterface

// File: rtl/galois_lfsr.sv
// Galois-form LFSR that advances one step only when 'step' is high.
// The state is exposed directly so the consumer can use the pre-advance value.
module galois_lfsr #(
  parameter int           W    = 16,
  parameter logic [W-1:0] SEED = 16'hACE1,
  parameter logic [W-1:0] POLY = 16'hB400
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  output logic [W-1:0] state
);

  logic [W-1:0] state_q;
  logic [W-1:0] state_d;

  // Next state: shift right and fold the feedback taps in when the LSB is set
  always_comb begin
    state_d = state_q;
    if (step) begin
      state_d = {1'b0, state_q[W-1:1]} ^ (state_q[0] ? POLY : {W{1'b0}});
    end else begin
      state_d = state_q;
    end
  end

  // State register; restarts from the seed on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/gilbert_error_injector.sv
// Gilbert-Elliott error injector: flips at most one bit of each accepted word,
// with the error probability chosen by the current channel state. One output
// register stage, full throughput, saturating word/error statistics.
module gilbert_error_injector
  import chan_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
  parameter int                CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [LFSR_W:0]         thr_good,
  input  logic [LFSR_W:0]         thr_bad,
  input  logic                    channel_state,
  input  logic                    clear_stats,
  gilbert_error_injector_if.slave bus,
  output logic [CNT_W-1:0]        word_count,
  output logic [CNT_W-1:0]        err_count
);

  localparam int IDX_W = $clog2(DATA_W);

  logic [LFSR_W-1:0] lfsr_s;
  logic              ready_s;
  logic              accept_s;
  logic [LFSR_W:0]   thr_s;
  logic              err_s;
  logic [IDX_W-1:0]  idx_s;
  logic [DATA_W-1:0] mask_s;

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [DATA_W-1:0] m_mask_q, m_mask_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  // The PRNG moves exactly once per accepted word, so stalls freeze it
  galois_lfsr #(
    .W    (LFSR_W),
    .SEED (SEED),
    .POLY (LFSR16_POLY)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (accept_s),
    .state (lfsr_s)
  );

  // Single register stage: a new word may enter whenever the slot is empty or draining
  assign ready_s  = !m_valid_q || bus.m_ready;
  assign accept_s = bus.s_valid && ready_s;

  // Error decision from the pre-advance PRNG value; the top bits pick the bit to flip
  always_comb begin
    thr_s  = (channel_state_e'(channel_state) == CH_GOOD) ? thr_good : thr_bad;
    err_s  = enable && ({1'b0, lfsr_s} < thr_s);
    idx_s  = lfsr_s[LFSR_W-1 -: IDX_W];
    mask_s = {DATA_W{1'b0}};
    if (err_s) begin
      mask_s = {{(DATA_W-1){1'b0}}, 1'b1} << idx_s;
    end else begin
      mask_s = {DATA_W{1'b0}};
    end
  end

  // Output stage next state: load on accept, drop valid once drained, hold on stall
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_mask_d  = m_mask_q;
    if (accept_s) begin
      m_valid_d = 1'b1;
      m_data_d  = bus.s_data ^ mask_s;
      m_mask_d  = mask_s;
    end else if (bus.m_ready) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  // Statistics next state: clear wins over a same-cycle accept; both counters saturate
  always_comb begin
    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (clear_stats) begin
      word_cnt_d = {CNT_W{1'b0}};
      err_cnt_d  = {CNT_W{1'b0}};
    end else if (accept_s) begin
      if (word_cnt_q != {CNT_W{1'b1}}) begin
        word_cnt_d = word_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        word_cnt_d = word_cnt_q;
      end
      if (err_s && (err_cnt_q != {CNT_W{1'b1}})) begin
        err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else begin
      word_cnt_d = word_cnt_q;
      err_cnt_d  = err_cnt_q;
    end
  end

  // Output and statistics registers; reset discards any in-flight word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid_q  <= 1'b0;
      m_data_q   <= {DATA_W{1'b0}};
      m_mask_q   <= {DATA_W{1'b0}};
      word_cnt_q <= {CNT_W{1'b0}};
      err_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_mask_q   <= m_mask_d;
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.s_ready    = ready_s;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = m_data_q;
  assign bus.m_err_mask = m_mask_q;
  assign word_count     = word_cnt_q;
  assign err_count      = err_cnt_q;

endmodule

// File: tb/tb_gilbert_error_injector.sv
// Bench for gilbert_error_injector: scenario tasks driven from one initial
// block, checked against a behavioural channel model kept in the bench.
module tb_gilbert_error_injector;

  localparam int    DW      = 8;
  localparam longint CNT_MAX = 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        channel_state;
  logic        clear_stats;
  logic        sat_clear;
  logic [16:0] thr_good;
  logic [16:0] thr_bad;
  logic [31:0] word_count;
  logic [31:0] err_count;
  logic [3:0]  sat_word_count;
  logic [3:0]  sat_err_count;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int          mdl_lfsr;
  bit          mdl_valid;
  logic [7:0]  mdl_data;
  logic [7:0]  mdl_mask;
  longint      mdl_words;
  longint      mdl_errs;
  bit          exp_ready;
  logic        obs_ready;

  always #5 clk = ~clk;

  gilbert_error_injector_if #(.DATA_W(DW)) bus ();
  gilbert_error_injector_if #(.DATA_W(DW)) sat_bus ();

  gilbert_error_injector #(
    .DATA_W (DW), .LFSR_W (16), .SEED (16'hACE1), .CNT_W (32)
  ) dut (
    .clk (clk), .reset (reset), .enable (enable),
    .thr_good (thr_good), .thr_bad (thr_bad),
    .channel_state (channel_state), .clear_stats (clear_stats),
    .bus (bus), .word_count (word_count), .err_count (err_count)
  );

  gilbert_error_injector #(
    .DATA_W (DW), .LFSR_W (16), .SEED (16'hACE1), .CNT_W (4)
  ) dut_sat (
    .clk (clk), .reset (reset), .enable (enable),
    .thr_good (thr_good), .thr_bad (thr_bad),
    .channel_state (channel_state), .clear_stats (sat_clear),
    .bus (sat_bus), .word_count (sat_word_count), .err_count (sat_err_count)
  );

  // One step of x^16+x^14+x^13+x^11+1 in Galois form, as plain arithmetic
  function automatic int lfsr_next(input int s);
    return (s / 2) ^ (((s % 2) == 1) ? 32'h0000_B400 : 32'h0000_0000);
  endfunction

  task automatic model_reset();
    mdl_lfsr  = 32'h0000_ACE1;
    mdl_valid = 1'b0;
    mdl_data  = 8'h00;
    mdl_mask  = 8'h00;
    mdl_words = 64'd0;
    mdl_errs  = 64'd0;
  endtask

  // Drive one cycle from a negedge, advance the model at the posedge, return at the next negedge
  task automatic drive_cycle(input logic v, input logic [7:0] d, input logic cs,
                             input logic mr, input logic clr);
    int thr;
    int idx;
    bit acc;
    bit err;
    bus.s_valid   = v;
    bus.s_data    = d;
    channel_state = cs;
    bus.m_ready   = mr;
    clear_stats   = clr;
    #1;
    exp_ready = !mdl_valid || mr;
    obs_ready = bus.s_ready;
    acc = v && exp_ready;
    thr = cs ? int'(thr_good) : int'(thr_bad);
    err = enable && (mdl_lfsr < thr);
    idx = mdl_lfsr / 8192;
    @(posedge clk);
    if (acc) begin
      mdl_mask  = err ? 8'(32'd1 << idx) : 8'h00;
      mdl_data  = d ^ mdl_mask;
      mdl_valid = 1'b1;
      mdl_lfsr  = lfsr_next(mdl_lfsr);
    end else if (mr) begin
      mdl_valid = 1'b0;
    end
    if (clr) begin
      mdl_words = 64'd0;
      mdl_errs  = 64'd0;
    end else if (acc) begin
      if (mdl_words < CNT_MAX) mdl_words++;
      if (err && mdl_errs < CNT_MAX) mdl_errs++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #2;
    vectors++; if (bus.m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
    vectors++; if (bus.m_data !== 8'h00) begin miscompares++; $display("FAIL reset_m_data: got %h want 00", bus.m_data); end
    vectors++; if (bus.m_err_mask !== 8'h00) begin miscompares++; $display("FAIL reset_m_err_mask: got %h want 00", bus.m_err_mask); end
    vectors++; if (word_count !== 32'd0 || err_count !== 32'd0) begin miscompares++; $display("FAIL reset_counts: got %0d/%0d want 0/0", word_count, err_count); end
    vectors++; if (sat_word_count !== 4'd0 || sat_bus.m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_sat: got cnt %0d valid %b want 0/0", sat_word_count, sat_bus.m_valid); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_transparent();
    enable = 1'b1; thr_good = 17'd0; thr_bad = 17'd0;
    for (int i = 0; i < 256; i++) begin
      drive_cycle(1'b1, 8'(i), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      vectors++; if (obs_ready !== 1'b1) begin miscompares++; $display("FAIL xp_s_ready[%0d]: got %b want 1", i, obs_ready); end
      vectors++; if (bus.m_valid !== 1'b1 || bus.m_data !== 8'(i) || bus.m_err_mask !== 8'h00) begin
        miscompares++; $display("FAIL xp_out[%0d]: got v=%b d=%h m=%h want v=1 d=%h m=00", i, bus.m_valid, bus.m_data, bus.m_err_mask, 8'(i));
      end
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    vectors++; if (bus.m_valid !== 1'b0) begin miscompares++; $display("FAIL xp_drain: got %b want 0", bus.m_valid); end
    vectors++; if (word_count !== 32'd256 || err_count !== 32'd0) begin miscompares++; $display("FAIL xp_counts: got %0d/%0d want 256/0", word_count, err_count); end
  endtask

  task automatic test_always_bad();
    logic [7:0] d;
    enable = 1'b1; thr_good = 17'd0; thr_bad = 17'h10000;
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    vectors++; if (word_count !== 32'd0 || err_count !== 32'd0) begin miscompares++; $display("FAIL bad_clear: got %0d/%0d want 0/0", word_count, err_count); end
    for (int i = 0; i < 100; i++) begin
      d = 8'($urandom);
      drive_cycle(1'b1, d, 1'b0, 1'b1, 1'b0);
      vectors++; if (!$onehot(bus.m_err_mask) || $countones(bus.m_data ^ d) != 1) begin
        miscompares++; $display("FAIL bad_onehot[%0d]: got mask %h data %h in %h want one flipped bit", i, bus.m_err_mask, bus.m_data, d);
      end
      vectors++; if (bus.m_err_mask !== mdl_mask || bus.m_data !== mdl_data) begin
        miscompares++; $display("FAIL bad_seq[%0d]: got %h/%h want %h/%h", i, bus.m_data, bus.m_err_mask, mdl_data, mdl_mask);
      end
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    vectors++; if (word_count !== 32'd100 || err_count !== 32'd100) begin miscompares++; $display("FAIL bad_counts: got %0d/%0d want 100/100", word_count, err_count); end
  endtask

  task automatic test_state_select();
    logic cs;
    enable = 1'b1; thr_good = 17'd0; thr_bad = 17'h10000;
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      cs = 1'(i % 2);
      drive_cycle(1'b1, 8'($urandom), cs, 1'b1, 1'b0);
      vectors++; if ((bus.m_err_mask != 8'h00) !== (cs == 1'b0) || bus.m_err_mask !== mdl_mask) begin
        miscompares++; $display("FAIL sel[%0d]: got mask %h (cs=%b) want %h", i, bus.m_err_mask, cs, mdl_mask);
      end
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    vectors++; if (word_count !== 32'd40 || err_count !== word_count / 2) begin miscompares++; $display("FAIL sel_counts: got %0d/%0d want 40/20", word_count, err_count); end
  endtask

  task automatic test_backpressure();
    logic [7:0] held_d;
    logic [7:0] held_m;
    enable = 1'b1; thr_good = 17'h10000; thr_bad = 17'h10000;
    drive_cycle(1'b1, 8'($urandom), 1'b1, 1'b1, 1'b0);
    held_d = mdl_data; held_m = mdl_mask;
    vectors++; if (bus.m_data !== held_d || bus.m_err_mask !== held_m) begin miscompares++; $display("FAIL bp_load: got %h/%h want %h/%h", bus.m_data, bus.m_err_mask, held_d, held_m); end
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      vectors++; if (obs_ready !== 1'b0) begin miscompares++; $display("FAIL bp_s_ready[%0d]: got %b want 0", i, obs_ready); end
      vectors++; if (bus.m_valid !== 1'b1 || bus.m_data !== held_d || bus.m_err_mask !== held_m) begin
        miscompares++; $display("FAIL bp_hold[%0d]: got v=%b %h/%h want 1 %h/%h", i, bus.m_valid, bus.m_data, bus.m_err_mask, held_d, held_m);
      end
    end
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      vectors++; if (bus.m_valid !== 1'b1 || bus.m_err_mask !== mdl_mask || bus.m_data !== mdl_data) begin
        miscompares++; $display("FAIL bp_release[%0d]: got %h/%h want %h/%h", i, bus.m_data, bus.m_err_mask, mdl_data, mdl_mask);
      end
    end
  endtask

  task automatic test_random();
    logic [16:0] choices [5];
    choices[0] = 17'd0; choices[1] = 17'd66; choices[2] = 17'd16384;
    choices[3] = 17'h10000; choices[4] = 17'd40000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        thr_good = choices[$urandom_range(0, 4)];
        thr_bad  = (($urandom_range(0, 1)) == 1) ? choices[$urandom_range(0, 4)] : 17'($urandom_range(0, 65536));
        enable   = ($urandom_range(0, 9) != 0);
      end
      drive_cycle(($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 31) == 0));
      vectors++; if (obs_ready !== exp_ready) begin miscompares++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, obs_ready, exp_ready); end
      vectors++; if (bus.m_valid !== mdl_valid || (mdl_valid && (bus.m_data !== mdl_data || bus.m_err_mask !== mdl_mask))) begin
        miscompares++; $display("FAIL rnd_out[%0d]: got v=%b %h/%h want v=%b %h/%h", i, bus.m_valid, bus.m_data, bus.m_err_mask, mdl_valid, mdl_data, mdl_mask);
      end
      vectors++; if (word_count !== 32'(mdl_words) || err_count !== 32'(mdl_errs)) begin
        miscompares++; $display("FAIL rnd_counts[%0d]: got %0d/%0d want %0d/%0d", i, word_count, err_count, mdl_words, mdl_errs);
      end
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    logic [7:0] first [8];
    enable = 1'b1; thr_good = 17'h10000; thr_bad = 17'h10000;
    reset = 1'b0; #2; reset = 1'b1; model_reset();
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0);
      first[i] = bus.m_err_mask;
      vectors++; if (bus.m_err_mask !== mdl_mask) begin miscompares++; $display("FAIL ar_seed_seq[%0d]: got %h want %h", i, bus.m_err_mask, mdl_mask); end
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++; if (bus.m_valid !== 1'b0) begin miscompares++; $display("FAIL ar_drop: got %b want 0", bus.m_valid); end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0);
      vectors++; if (bus.m_err_mask !== first[i] || bus.m_err_mask !== mdl_mask) begin
        miscompares++; $display("FAIL ar_repeat[%0d]: got %h want %h", i, bus.m_err_mask, first[i]);
      end
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_saturation();
    int exp_cnt;
    enable = 1'b1; thr_good = 17'h10000; thr_bad = 17'h10000;
    for (int i = 0; i < 20; i++) begin
      sat_bus.s_valid = 1'b1; sat_bus.s_data = 8'($urandom); sat_bus.m_ready = 1'b1; sat_clear = 1'b0;
      @(posedge clk); @(negedge clk);
      exp_cnt = (i + 1 > 15) ? 15 : i + 1;
      vectors++; if (sat_bus.m_valid !== 1'b1 || !$onehot(sat_bus.m_err_mask)) begin
        miscompares++; $display("FAIL sat_mask[%0d]: got v=%b mask %h want one-hot", i, sat_bus.m_valid, sat_bus.m_err_mask);
      end
      vectors++; if (sat_word_count !== 4'(exp_cnt) || sat_err_count !== 4'(exp_cnt)) begin
        miscompares++; $display("FAIL sat_count[%0d]: got %0d/%0d want %0d/%0d", i, sat_word_count, sat_err_count, exp_cnt, exp_cnt);
      end
    end
    sat_clear = 1'b1;
    @(posedge clk); @(negedge clk);
    vectors++; if (sat_word_count !== 4'd0 || sat_err_count !== 4'd0 || sat_bus.m_valid !== 1'b1) begin
      miscompares++; $display("FAIL sat_clear_accept: got %0d/%0d v=%b want 0/0 v=1", sat_word_count, sat_err_count, sat_bus.m_valid);
    end
    sat_clear = 1'b0;
    @(posedge clk); @(negedge clk);
    vectors++; if (sat_word_count !== 4'd1 || sat_err_count !== 4'd1) begin
      miscompares++; $display("FAIL sat_after_clear: got %0d/%0d want 1/1", sat_word_count, sat_err_count);
    end
    sat_bus.s_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; channel_state = 1'b1; clear_stats = 1'b0; sat_clear = 1'b0;
    thr_good = 17'd66; thr_bad = 17'd16384;
    bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.m_ready = 1'b1;
    sat_bus.s_valid = 1'b0; sat_bus.s_data = 8'h00; sat_bus.m_ready = 1'b1;
    model_reset();
    test_reset();
    test_transparent();
    test_always_bad();
    test_state_select();
    test_backpressure();
    test_random();
    test_async_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
